// File: rtl/cim_core_req_pkg.sv
// Shared types, address map and address decode for the CIM core request router.
package cim_core_req_pkg;

    typedef enum logic [2:0] {
        TGT_REGFILE = 3'd0,
        TGT_SRAM    = 3'd1,
        TGT_MACRO   = 3'd2,
        TGT_EDRAM   = 3'd3,
        TGT_DECERR  = 3'd4
    } tgt_e;

    localparam int NUM_SLV  = 4;
    localparam int DEC_AW   = 64;

    localparam logic [DEC_AW-1:0] SLV_BASE [NUM_SLV] = '{
        64'h0000_0000_2000_0000, 64'h0000_0000_2800_0000,
        64'h0000_0000_3000_0000, 64'h0000_0000_5000_0000
    };
    localparam logic [DEC_AW-1:0] SLV_LEN [NUM_SLV] = '{
        64'h0000_0000_0800_0000, 64'h0000_0000_0800_0000,
        64'h0000_0000_2000_0000, 64'h0000_0000_2000_0000
    };

    typedef struct packed {
        tgt_e              tgt;
        logic [DEC_AW-1:0] offset;
    } decode_t;

    // Address is zero-extended to 64 bits by the caller; windows never overlap.
    function automatic decode_t decode(input logic [DEC_AW-1:0] addr);
        decode_t res;
        res.tgt    = TGT_DECERR;
        res.offset = '0;
        for (int s = 0; s < NUM_SLV; s++) begin
            if (addr >= SLV_BASE[s] && addr < SLV_BASE[s] + SLV_LEN[s]) begin
                res.tgt    = tgt_e'(3'(s));
                res.offset = addr - SLV_BASE[s];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/cim_core_tgt_fifo.sv
// In-order tracking FIFO of request targets; head is visible combinationally.
module cim_core_tgt_fifo
    import cim_core_req_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push,
    input  tgt_e                     pushTgt,
    input  logic                     pop,
    output tgt_e                     headTgt,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    tgt_e         mem [DEPTH];
    logic [AW:0]  wrPtrReg;
    logic [AW:0]  rdPtrReg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
        end else begin
            if (push && !full) wrPtrReg <= wrPtrReg + 1'b1;
            if (pop && !empty) rdPtrReg <= rdPtrReg + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !full) mem[wrPtrReg[AW-1:0]] <= pushTgt;
    end

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign empty   = (wrPtrReg == rdPtrReg);
    assign full    = (wrPtrReg[AW] != rdPtrReg[AW]) && (wrPtrReg[AW-1:0] == rdPtrReg[AW-1:0]);
    assign count   = wrPtrReg - rdPtrReg;
    assign headTgt = mem[rdPtrReg[AW-1:0]];

endmodule

// File: rtl/cim_core_req_demux.sv
// Routes one request stream to the CIM core slaves and returns responses in request order.
module cim_core_req_demux
    import cim_core_req_pkg::*;
#(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int MAX_OUTST = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [ADDR_W-1:0]             req_addr_i,
    input  logic                          req_we_i,
    input  logic [DATA_W-1:0]             req_wdata_i,
    input  logic [DATA_W/8-1:0]           req_be_i,
    output logic [3:0]                    slv_req_valid_o,
    input  logic [3:0]                    slv_req_ready_i,
    output logic [ADDR_W-1:0]             slv_addr_o,
    output logic                          slv_we_o,
    output logic [DATA_W-1:0]             slv_wdata_o,
    output logic [DATA_W/8-1:0]           slv_be_o,
    input  logic [3:0]                    slv_rsp_valid_i,
    output logic [3:0]                    slv_rsp_ready_o,
    input  logic [3:0][DATA_W-1:0]        slv_rsp_rdata_i,
    input  logic [3:0]                    slv_rsp_err_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [DATA_W-1:0]             rsp_rdata_o,
    output logic                          rsp_err_o,
    output logic [$clog2(MAX_OUTST):0]    outst_o
);
    decode_t dec;
    tgt_e    headTgt;
    logic    full;
    logic    empty;
    logic    push;
    logic    pop;
    logic    headIsErr;

    assign dec = decode(64'(req_addr_i));

    assign slv_addr_o  = ADDR_W'(dec.offset);
    assign slv_we_o    = req_we_i;
    assign slv_wdata_o = req_wdata_i;
    assign slv_be_o    = req_be_i;

    // DECERR requests are absorbed locally, so only real slaves can stall us.
    assign req_ready_o = !full && ((dec.tgt == TGT_DECERR) ? 1'b1 : slv_req_ready_i[dec.tgt[1:0]]);
    assign push        = req_valid_i && req_ready_o;

    assign headIsErr = (headTgt == TGT_DECERR);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : gSlv
            assign slv_req_valid_o[gi] = req_valid_i && !full && (dec.tgt == tgt_e'(3'(gi)));
            assign slv_rsp_ready_o[gi] = !empty && (headTgt == tgt_e'(3'(gi))) && rsp_ready_i;
        end
    endgenerate

    always_comb begin
        rsp_valid_o = 1'b0;
        rsp_rdata_o = '0;
        rsp_err_o   = 1'b0;
        if (!empty) begin
            if (headIsErr) begin
                rsp_valid_o = 1'b1;
                rsp_err_o   = 1'b1;
            end else begin
                rsp_valid_o = slv_rsp_valid_i[headTgt[1:0]];
                rsp_rdata_o = slv_rsp_rdata_i[headTgt[1:0]];
                rsp_err_o   = slv_rsp_err_i[headTgt[1:0]];
            end
        end
    end

    assign pop = rsp_valid_o && rsp_ready_i;

    cim_core_tgt_fifo #(
        .DEPTH (MAX_OUTST)
    ) uTgtFifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push    (push),
        .pushTgt (dec.tgt),
        .pop     (pop),
        .headTgt (headTgt),
        .full    (full),
        .empty   (empty),
        .count   (outst_o)
    );

endmodule

// File: tb/tb_cim_core_req_demux.sv
// Directed bench for the CIM core request router: routing, ordering, fill and reset.
module tb_cim_core_req_demux;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int MAX_OUTST = 4;

    logic                       clk_i = 1'b0;
    logic                       rst_i;
    logic                       req_valid_i;
    logic                       req_ready_o;
    logic [ADDR_W-1:0]          req_addr_i;
    logic                       req_we_i;
    logic [DATA_W-1:0]          req_wdata_i;
    logic [DATA_W/8-1:0]        req_be_i;
    logic [3:0]                 slv_req_valid_o;
    logic [3:0]                 slv_req_ready_i;
    logic [ADDR_W-1:0]          slv_addr_o;
    logic                       slv_we_o;
    logic [DATA_W-1:0]          slv_wdata_o;
    logic [DATA_W/8-1:0]        slv_be_o;
    logic [3:0]                 slv_rsp_valid_i;
    logic [3:0]                 slv_rsp_ready_o;
    logic [3:0][DATA_W-1:0]     slv_rsp_rdata_i;
    logic [3:0]                 slv_rsp_err_i;
    logic                       rsp_valid_o;
    logic                       rsp_ready_i;
    logic [DATA_W-1:0]          rsp_rdata_o;
    logic                       rsp_err_o;
    logic [$clog2(MAX_OUTST):0] outst_o;

    int numChecks = 0;
    int numErrors = 0;

    always #5 clk_i = ~clk_i;

    cim_core_req_demux #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MAX_OUTST (MAX_OUTST)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_addr_i      (req_addr_i),
        .req_we_i        (req_we_i),
        .req_wdata_i     (req_wdata_i),
        .req_be_i        (req_be_i),
        .slv_req_valid_o (slv_req_valid_o),
        .slv_req_ready_i (slv_req_ready_i),
        .slv_addr_o      (slv_addr_o),
        .slv_we_o        (slv_we_o),
        .slv_wdata_o     (slv_wdata_o),
        .slv_be_o        (slv_be_o),
        .slv_rsp_valid_i (slv_rsp_valid_i),
        .slv_rsp_ready_o (slv_rsp_ready_o),
        .slv_rsp_rdata_i (slv_rsp_rdata_i),
        .slv_rsp_err_i   (slv_rsp_err_i),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_ready_i     (rsp_ready_i),
        .rsp_rdata_o     (rsp_rdata_o),
        .rsp_err_o       (rsp_err_o),
        .outst_o         (outst_o)
    );

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        numChecks++;
        if (got !== exp) begin
            numErrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    typedef struct {
        logic [63:0] addr;
        logic [3:0]  vld;
        logic [63:0] off;
    } bnd_t;

    bnd_t bnd [10];

    initial begin
        bnd[0] = '{64'h2FFF_FFFF, 4'b0010, 64'h07FF_FFFF};
        bnd[1] = '{64'h3000_0000, 4'b0100, 64'h0};
        bnd[2] = '{64'h6FFF_FFFF, 4'b1000, 64'h1FFF_FFFF};
        bnd[3] = '{64'h1FFF_FFFF, 4'b0000, 64'h0};
        bnd[4] = '{64'h2000_0000, 4'b0001, 64'h0};
        bnd[5] = '{64'h27FF_FFFF, 4'b0001, 64'h07FF_FFFF};
        bnd[6] = '{64'h4FFF_FFFF, 4'b0100, 64'h1FFF_FFFF};
        bnd[7] = '{64'h5000_0000, 4'b1000, 64'h0};
        bnd[8] = '{64'h7000_0000, 4'b0000, 64'h0};
        bnd[9] = '{64'h1_2000_0000, 4'b0000, 64'h0};

        rst_i           = 1'b1;
        req_valid_i     = 1'b0;
        req_addr_i      = '0;
        req_we_i        = 1'b0;
        req_wdata_i     = '0;
        req_be_i        = '0;
        slv_req_ready_i = '0;
        slv_rsp_valid_i = '0;
        slv_rsp_rdata_i = '0;
        slv_rsp_err_i   = '0;
        rsp_ready_i     = 1'b0;
        tick();
        checkVal("rst_outst", 64'(outst_o), 64'd0);
        checkVal("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        checkVal("rst_slv_rsp_ready", 64'(slv_rsp_ready_o), 64'd0);
        tick();
        rst_i = 1'b0;
        tick();

        // Write to SRAM, response the following cycle.
        $display("txn: write 0x28000010 -> SRAM");
        req_valid_i = 1'b1; req_addr_i = 64'h2800_0010; req_we_i = 1'b1;
        req_wdata_i = 64'hDEAD_BEEF_0000_1234; req_be_i = 8'hFF;
        slv_req_ready_i = 4'b0010; rsp_ready_i = 1'b1;
        slv_rsp_valid_i = 4'b0010; slv_rsp_rdata_i[1] = 64'hABCD;
        #1;
        checkVal("wr_slv_req_valid", 64'(slv_req_valid_o), 64'h2);
        checkVal("wr_slv_addr", slv_addr_o, 64'h10);
        checkVal("wr_req_ready", 64'(req_ready_o), 64'd1);
        checkVal("wr_slv_we", 64'(slv_we_o), 64'd1);
        checkVal("wr_slv_wdata", slv_wdata_o, 64'hDEAD_BEEF_0000_1234);
        checkVal("wr_early_rsp_held", 64'(rsp_valid_o), 64'd0);
        tick();
        req_valid_i = 1'b0; req_we_i = 1'b0;
        #1;
        checkVal("wr_outst1", 64'(outst_o), 64'd1);
        checkVal("wr_rsp_valid", 64'(rsp_valid_o), 64'd1);
        checkVal("wr_rsp_rdata", rsp_rdata_o, 64'hABCD);
        checkVal("wr_rsp_err", 64'(rsp_err_o), 64'd0);
        checkVal("wr_slv_rsp_ready", 64'(slv_rsp_ready_o), 64'h2);
        tick();
        slv_rsp_valid_i = '0;
        #1;
        checkVal("wr_outst0", 64'(outst_o), 64'd0);
        checkVal("wr_rsp_idle", 64'(rsp_valid_o), 64'd0);

        // Two unmapped reads back to back.
        $display("txn: read 0x10000000, read 0x70000000 -> DECERR");
        req_valid_i = 1'b1; req_addr_i = 64'h1000_0000; slv_req_ready_i = '0;
        #1;
        checkVal("de0_slv_req_valid", 64'(slv_req_valid_o), 64'd0);
        checkVal("de0_req_ready", 64'(req_ready_o), 64'd1);
        checkVal("de0_slv_addr", slv_addr_o, 64'd0);
        tick();
        req_addr_i = 64'h7000_0000;
        #1;
        checkVal("de1_rsp_valid", 64'(rsp_valid_o), 64'd1);
        checkVal("de1_rsp_err", 64'(rsp_err_o), 64'd1);
        checkVal("de1_rsp_rdata", rsp_rdata_o, 64'd0);
        checkVal("de1_req_ready", 64'(req_ready_o), 64'd1);
        tick();
        req_valid_i = 1'b0;
        #1;
        checkVal("de2_rsp_valid", 64'(rsp_valid_o), 64'd1);
        checkVal("de2_rsp_err", 64'(rsp_err_o), 64'd1);
        checkVal("de2_outst", 64'(outst_o), 64'd1);
        tick();
        checkVal("de3_outst", 64'(outst_o), 64'd0);
        checkVal("de3_rsp_valid", 64'(rsp_valid_o), 64'd0);

        // Window boundaries, decode only (slaves not ready, valid dropped before the edge).
        slv_req_ready_i = '0;
        for (int i = 0; i < 10; i++) begin
            $display("txn: decode 0x%0h", bnd[i].addr);
            req_valid_i = 1'b1; req_addr_i = bnd[i].addr;
            #1;
            checkVal($sformatf("bnd%0d_vld", i), 64'(slv_req_valid_o), 64'(bnd[i].vld));
            checkVal($sformatf("bnd%0d_off", i), slv_addr_o, bnd[i].off);
            req_valid_i = 1'b0;
            tick();
        end
        checkVal("bnd_outst", 64'(outst_o), 64'd0);

        // Out-of-order slave responses must be returned in request order.
        $display("txn: read eDRAM 0x50000040, read Reg_file 0x20000008");
        rsp_ready_i = 1'b1;
        req_valid_i = 1'b1; req_addr_i = 64'h5000_0040; slv_req_ready_i = 4'b1000;
        #1;
        checkVal("ro_vld_edram", 64'(slv_req_valid_o), 64'h8);
        checkVal("ro_off_edram", slv_addr_o, 64'h40);
        tick();
        req_addr_i = 64'h2000_0008; slv_req_ready_i = 4'b0001;
        #1;
        checkVal("ro_vld_reg", 64'(slv_req_valid_o), 64'h1);
        tick();
        req_valid_i = 1'b0;
        slv_rsp_valid_i = 4'b0001; slv_rsp_rdata_i[0] = 64'h1111;
        #1;
        checkVal("ro_outst2", 64'(outst_o), 64'd2);
        checkVal("ro_held_valid", 64'(rsp_valid_o), 64'd0);
        checkVal("ro_held_ready", 64'(slv_rsp_ready_o), 64'h8);
        tick();
        slv_rsp_valid_i = 4'b1001; slv_rsp_rdata_i[3] = 64'h3333;
        #1;
        checkVal("ro_first_valid", 64'(rsp_valid_o), 64'd1);
        checkVal("ro_first_rdata", rsp_rdata_o, 64'h3333);
        checkVal("ro_first_ready", 64'(slv_rsp_ready_o), 64'h8);
        tick();
        slv_rsp_valid_i = 4'b0001;
        #1;
        checkVal("ro_second_valid", 64'(rsp_valid_o), 64'd1);
        checkVal("ro_second_rdata", rsp_rdata_o, 64'h1111);
        checkVal("ro_second_ready", 64'(slv_rsp_ready_o), 64'h1);
        checkVal("ro_outst1", 64'(outst_o), 64'd1);
        tick();
        slv_rsp_valid_i = '0;
        #1;
        checkVal("ro_outst0", 64'(outst_o), 64'd0);

        // Fill the tracker and check back-pressure at full.
        rsp_ready_i = 1'b0; slv_req_ready_i = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            $display("txn: fill read 0x%0h", 64'h2800_0000 + 64'(i * 8));
            req_valid_i = 1'b1; req_addr_i = 64'h2800_0000 + 64'(i * 8);
            tick();
        end
        $display("txn: 5th read 0x30000100 while full");
        req_addr_i = 64'h3000_0100;
        #1;
        checkVal("fill_outst4", 64'(outst_o), 64'd4);
        checkVal("fill_req_ready", 64'(req_ready_o), 64'd0);
        checkVal("fill_slv_req_valid", 64'(slv_req_valid_o), 64'd0);
        slv_rsp_valid_i = 4'b0010; slv_rsp_rdata_i[1] = 64'h5555; rsp_ready_i = 1'b1;
        #1;
        checkVal("fill_pop_valid", 64'(rsp_valid_o), 64'd1);
        checkVal("fill_no_push_at_full", 64'(req_ready_o), 64'd0);
        tick();
        slv_rsp_valid_i = '0; rsp_ready_i = 1'b0;
        #1;
        checkVal("fill_outst3", 64'(outst_o), 64'd3);
        checkVal("fill_req_ready_again", 64'(req_ready_o), 64'd1);
        checkVal("fill_slv_req_valid_macro", 64'(slv_req_valid_o), 64'h4);
        tick();
        req_valid_i = 1'b0;
        #1;
        checkVal("fill_outst4_again", 64'(outst_o), 64'd4);

        // Drain one, then reset with three outstanding.
        slv_rsp_valid_i = 4'b0010; rsp_ready_i = 1'b1;
        tick();
        checkVal("pre_rst_outst3", 64'(outst_o), 64'd3);
        checkVal("pre_rst_rsp_valid", 64'(rsp_valid_o), 64'd1);
        $display("txn: reset with 3 outstanding");
        rst_i = 1'b1;
        #1;
        checkVal("mid_rst_outst", 64'(outst_o), 64'd0);
        checkVal("mid_rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        checkVal("mid_rst_slv_rsp_ready", 64'(slv_rsp_ready_o), 64'd0);
        tick();
        rst_i = 1'b0; slv_rsp_valid_i = '0;
        tick();

        $display("txn: read Macro 0x30000000 after reset");
        req_valid_i = 1'b1; req_addr_i = 64'h3000_0000; slv_req_ready_i = 4'b0100;
        #1;
        checkVal("post_rst_vld", 64'(slv_req_valid_o), 64'h4);
        tick();
        req_valid_i = 1'b0;
        slv_rsp_valid_i = 4'b0100; slv_rsp_rdata_i[2] = 64'h2222; slv_rsp_err_i = 4'b0000;
        #1;
        checkVal("post_rst_outst1", 64'(outst_o), 64'd1);
        checkVal("post_rst_rsp_valid", 64'(rsp_valid_o), 64'd1);
        checkVal("post_rst_rsp_rdata", rsp_rdata_o, 64'h2222);
        checkVal("post_rst_rsp_err", 64'(rsp_err_o), 64'd0);
        tick();
        slv_rsp_valid_i = '0;
        #1;
        checkVal("post_rst_outst0", 64'(outst_o), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
        $finish;
    end

endmodule

// File: doc/cim_core_req_demux.md
# cim_core_req_demux

Request router in front of the CIM core slaves. Takes one upstream valid/ready memory-request stream, decodes each address against the CIM core map (Reg_file, SRAM, Macro, eDRAM), and forwards it to the owning slave with the slave base subtracted. It tracks up to `MAX_OUTST` outstanding requests and returns responses to the master strictly in request order. Unmapped addresses produce a locally generated decode-error response.

## Interface
- `ADDR_W`, default 64, request address width.
- `DATA_W`, default 64, data width.
- `MAX_OUTST`, default 4, depth of the in-order tracking FIFO; power of two, ≥2.
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `req_valid_i` in 1, `req_ready_o` out 1: upstream request handshake.
- `req_addr_i` in ADDR_W: absolute address.
- `req_we_i` in 1: write enable.
- `req_wdata_i` in DATA_W: write data.
- `req_be_i` in DATA_W/8: byte enables.
- `slv_req_valid_o` out 4, `slv_req_ready_i` in 4: per-slave request handshake, indexed by slave number (Reg_file=0, SRAM=1, Macro=2, eDRAM=3).
- `slv_addr_o` out ADDR_W: offset (`addr - base`), shared by all slaves.
- `slv_we_o`, `slv_wdata_o`, `slv_be_o` out: shared by all slaves, passed through.
- `slv_rsp_valid_i` in 4, `slv_rsp_ready_o` out 4: per-slave response handshake.
- `slv_rsp_rdata_i` in 4×DATA_W, `slv_rsp_err_i` in 4: per-slave response data and error.
- `rsp_valid_o` out 1, `rsp_ready_i` in 1, `rsp_rdata_o` out DATA_W, `rsp_err_o` out 1: upstream response.
- `outst_o` out $clog2(MAX_OUTST)+1: current outstanding count.

## Operation
- Decode (combinational): target = s if `base_s <= addr < base_s + length_s`, else DECERR (4).
  - Windows: Reg_file 0x2000_0000 +0x800_0000; SRAM 0x2800_0000 +0x800_0000; Macro 0x3000_0000 +0x2000_0000; eDRAM 0x5000_0000 +0x2000_0000.
  - Compares are full ADDR_W unsigned. Offset is the ADDR_W subtraction; for DECERR the offset is 0.
- Request path:
  - `slv_req_valid_o[t] = req_valid_i & !full`, only for the decoded target t. Other bits are 0.
  - `req_ready_o = !full & (t==DECERR ? 1 : slv_req_ready_i[t])`.
  - Accept = `req_valid_i & req_ready_o`. On accept, push t into the tracking FIFO.
  - `full` does not depend on a same-cycle pop: no push at full, even if a pop occurs.
- Response path, driven by FIFO head h (only when FIFO non-empty):
  - h<4: `rsp_valid_o = slv_rsp_valid_i[h]`, rdata and err from slave h, `slv_rsp_ready_o[h] = rsp_ready_i`. All other `slv_rsp_ready_o` are 0.
  - h==DECERR: `rsp_valid_o = 1`, `rsp_rdata_o = 0`, `rsp_err_o = 1`.
  - Pop on `rsp_valid_o & rsp_ready_i`.
- Responses from non-head slaves are back-pressured until they reach the head. Each slave must answer its own requests in order.
- `outst_o` = FIFO occupancy. Push and pop in the same cycle leave it unchanged.

## Timing
- Request path and response path: zero latency (combinational valid-to-valid).
- Earliest response: one cycle after accept (FIFO write is registered). A slave response asserted in the accept cycle is held off until the next cycle.
- DECERR response: `rsp_valid_o` high the cycle after accept if it is the head. Back-to-back DECERRs sustain 1 per cycle.
- Throughput: 1 request/cycle while not full.
- Reset values: FIFO empty, `outst_o=0`, `rsp_valid_o=0`, all `slv_rsp_ready_o=0`. `slv_req_valid_o` follows `req_valid_i` (no state needed).
- Reset mid-operation drops all outstanding entries. Slaves share `rst_i` and must drop theirs too.
- Upstream must hold the request stable while valid and not ready. The block adds no skid buffering.

## Structure
- Package `cim_core_req_pkg`:
  - Target enum (4 slaves plus `TGT_DECERR=4`, 3 bits).
  - Base/length constants equal to the core address map.
  - `decode(addr)` function returning target and offset.
- Sub-module `cim_core_tgt_fifo`: synchronous FIFO of 3-bit targets with `full`, `empty` and `count`, depth `MAX_OUTST`, wrap-around pointers with an extra MSB.

## Test plan
- Write to 0x2800_0010, SRAM ready → `slv_req_valid_o=4'b0010`, `slv_addr_o=0x10`; SRAM responds next cycle → `rsp_valid_o`, err 0, `outst_o` 1→0.
- Read 0x1000_0000 and read 0x7000_0000 → no slave valid, two consecutive responses with `rsp_err_o=1`, rdata 0.
- Boundaries: 0x2FFF_FFFF → SRAM (offset 0x7FF_FFFF); 0x3000_0000 → Macro (offset 0); 0x6FFF_FFFF → eDRAM; 0x1FFF_FFFF → DECERR.
- Reorder: read eDRAM, then read Reg_file; Reg_file responds first → held (`slv_rsp_ready_o[0]=0`) until the eDRAM response passes; upstream sees eDRAM then Reg_file.
- Fill: 4 requests with `rsp_ready_i=0` → `outst_o=4`, 5th `req_ready_o=0`; one pop → 5th accepted the following cycle.
- Assert `rst_i` with 3 outstanding → same cycle `outst_o=0`, `rsp_valid_o=0`; after release, a new request completes normally.
